// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the RV32 core: CSR access, counters,
// prioritised interrupts, exception/interrupt trap entry and MRET return.
module csr_trap_unit #(
  parameter int          XLEN    = 32,
  parameter logic [31:0] HART_ID = 32'd0,
  parameter int          N_LIRQ  = 4,
  parameter int          CNT_W   = 64,
  parameter bit          VEC_EN  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_csr_en,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_wd,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_illegal,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_badaddr,
  input  logic              i_ex_valid,
  input  logic [3:0]        i_ex_cause,
  input  logic              i_retire,
  input  logic              i_int_ok,
  input  logic              i_irq_msi,
  input  logic              i_irq_mti,
  input  logic              i_irq_mei,
  input  logic [N_LIRQ-1:0] i_irq_local,
  output logic              o_trap,
  output logic [XLEN-1:0]   o_trap_pc,
  output logic              o_eret,
  output logic [XLEN-1:0]   o_epc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MRET     = 12'h302;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCHID  = 12'hF12;
  localparam logic [11:0] A_MIMPID   = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | (32'((64'd1 << N_LIRQ) - 64'd1) << 16);
  localparam logic [31:0] MTVEC_MASK = VEC_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic              st_mie, st_mpie;
  logic [31:0]       mie_r, mtvec, mepc, mcause, mtval, mscratch;
  logic              cy_inh, ir_inh;
  logic [CNT_W-1:0]  mcycle, minstret;
  logic [63:0]       cy64, ir64;

  logic [2:0]  funct3;
  logic [11:0] addr;
  logic [4:0]  zimm;
  logic        csr_op, wr_req, do_wr, hit, irq_take;
  logic [31:0] src, rdata, wval, mip, pend, ex_tval;
  logic [4:0]  irq_code;

  assign funct3 = i_inst[14:12];
  assign addr   = i_inst[31:20];
  assign zimm   = i_inst[19:15];
  assign cy64   = 64'(mcycle);
  assign ir64   = 64'(minstret);

  always_comb begin
    mip = '0;
    mip[3]  = i_irq_msi;
    mip[7]  = i_irq_mti;
    mip[11] = i_irq_mei;
    mip[16 +: N_LIRQ] = i_irq_local;
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (addr)
      A_MSTATUS:  rdata = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
      A_MISA:     rdata = 32'h4000_0100;
      A_MIE:      rdata = mie_r;
      A_MTVEC:    rdata = mtvec;
      A_MCNTINH:  rdata = {29'd0, ir_inh, 1'b0, cy_inh};
      A_MSCRATCH: rdata = mscratch;
      A_MEPC:     rdata = mepc;
      A_MCAUSE:   rdata = mcause;
      A_MTVAL:    rdata = mtval;
      A_MIP:      rdata = mip;
      A_MCYCLE:   rdata = cy64[31:0];
      A_MCYCLEH:  rdata = cy64[63:32];
      A_MINSTRET: rdata = ir64[31:0];
      A_MINSTRH:  rdata = ir64[63:32];
      A_MVENDOR, A_MARCHID, A_MIMPID: rdata = '0;
      A_MHARTID:  rdata = HART_ID;
      default:    hit = 1'b0;
    endcase
  end

  // Set/clear with rs1 field of zero is a pure read, so it is legal on read-only CSRs.
  assign csr_op    = i_csr_en && (funct3 != 3'b000);
  assign wr_req    = csr_op && ((funct3[1:0] == 2'b01) || (funct3[1] && (zimm != 5'd0)));
  assign o_illegal = csr_op && ((funct3 == 3'b100) || !hit || ((addr[11:10] == 2'b11) && wr_req));
  assign o_rd      = i_csr_en ? rdata : '0;
  assign src       = funct3[2] ? {27'd0, zimm} : i_wd;

  always_comb begin
    case (funct3[1:0])
      2'b01:   wval = src;
      2'b10:   wval = rdata | src;
      2'b11:   wval = rdata & ~src;
      default: wval = rdata;
    endcase
  end

  assign pend = mip & mie_r;

  // Lowest priority is assigned first so higher-priority sources overwrite it.
  always_comb begin
    irq_code = '0;
    for (int i = N_LIRQ - 1; i >= 0; i--)
      if (pend[16 + i]) irq_code = 5'(16 + i);
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  assign irq_take  = st_mie && (pend != '0) && i_int_ok && !i_ex_valid;
  assign o_trap    = i_ex_valid || irq_take;
  assign do_wr     = wr_req && !o_illegal && !o_trap;
  assign o_trap_pc = {mtvec[31:2], 2'b00} +
                     ((irq_take && mtvec[1:0] == 2'b01) ? {25'd0, irq_code, 2'b00} : 32'd0);
  assign o_eret    = i_csr_en && (funct3 == 3'b000) && (addr == A_MRET);
  assign o_epc     = {mepc[31:2], 2'b00};

  always_comb begin
    case (i_ex_cause)
      4'd0, 4'd4, 4'd6: ex_tval = i_badaddr;
      4'd2:             ex_tval = i_inst;
      4'd3:             ex_tval = i_pc;
      default:          ex_tval = '0;
    endcase
  end

  // A CSR write to either half replaces that cycle's increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (do_wr && addr == A_MCYCLE)       mcycle[31:0]       <= wval;
      else if (do_wr && addr == A_MCYCLEH) mcycle[CNT_W-1:32] <= wval[CNT_W-33:0];
      else if (!cy_inh)                    mcycle             <= mcycle + CNT_W'(1);
      if (do_wr && addr == A_MINSTRET)     minstret[31:0]       <= wval;
      else if (do_wr && addr == A_MINSTRH) minstret[CNT_W-1:32] <= wval[CNT_W-33:0];
      else if (i_retire && !ir_inh)        minstret             <= minstret + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_r    <= '0;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mscratch <= '0;
      cy_inh   <= 1'b0;
      ir_inh   <= 1'b0;
    end else if (o_trap) begin
      mepc    <= {i_pc[31:2], 2'b00};
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
      if (i_ex_valid) begin
        mcause <= {28'd0, i_ex_cause};
        mtval  <= ex_tval;
      end else begin
        mcause <= {1'b1, 26'd0, irq_code};
        mtval  <= '0;
      end
    end else if (o_eret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (do_wr) begin
      case (addr)
        A_MSTATUS: begin
          st_mie  <= wval[3];
          st_mpie <= wval[7];
        end
        A_MIE:      mie_r    <= wval & MIE_MASK;
        A_MTVEC:    mtvec    <= wval & MTVEC_MASK;
        A_MCNTINH: begin
          cy_inh <= wval[0];
          ir_inh <= wval[2];
        end
        A_MSCRATCH: mscratch <= wval;
        A_MEPC:     mepc     <= {wval[31:2], 2'b00};
        A_MCAUSE:   mcause   <= wval;
        A_MTVAL:    mtval    <= wval;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: constant vector table, directed trap/counter sequences and
// randomized traffic checked every cycle against a behavioural CSR/trap model.
module tb_csr_trap_unit;

  localparam logic [31:0] HART = 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [31:0] inst, wd, pc, badaddr;
  logic        ex_valid, retire, int_ok, msi, mti, mei;
  logic [3:0]  ex_cause;
  logic [3:0]  lirq;
  logic [31:0] o_rd, o_trap_pc, o_epc;
  logic        o_illegal, o_trap, o_eret;

  csr_trap_unit #(.XLEN(32), .HART_ID(HART), .N_LIRQ(4), .CNT_W(64), .VEC_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_csr_en(csr_en), .i_inst(inst), .i_wd(wd),
    .o_rd(o_rd), .o_illegal(o_illegal), .i_pc(pc), .i_badaddr(badaddr),
    .i_ex_valid(ex_valid), .i_ex_cause(ex_cause), .i_retire(retire), .i_int_ok(int_ok),
    .i_irq_msi(msi), .i_irq_mti(mti), .i_irq_mei(mei), .i_irq_local(lirq),
    .o_trap(o_trap), .o_trap_pc(o_trap_pc), .o_eret(o_eret), .o_epc(o_epc)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  bit chk = 1'b0;

  // Reference state
  bit          m_msie, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_inh;
  logic [63:0] m_cyc, m_ins;
  // Reference outputs for the current cycle
  logic [31:0] e_rd, e_tpc, e_epc, e_wv;
  logic        e_ill, e_trap, e_eret, e_do_wr;
  logic [11:0] e_a;
  int          e_code;
  int          PRIO[7] = '{11, 3, 7, 16, 17, 18, 19};

  function automatic logic [31:0] ci(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] rs);
    return {a, rs, f3, 5'd1, 7'h73};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic eval();
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  z;
    logic [31:0] v, src, mip, pend;
    logic        hit, wr, take;
    int          code;
    f3 = inst[14:12]; a = inst[31:20]; z = inst[19:15];
    mip = (32'(msi) << 3) | (32'(mti) << 7) | (32'(mei) << 11) | (32'(lirq) << 16);
    hit = 1'b1;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_msie) << 3);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h320: v = m_inh;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = mip;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hF11, 12'hF12, 12'hF13: v = 0;
      12'hF14: v = HART;
      default: begin v = 0; hit = 1'b0; end
    endcase
    wr    = csr_en && f3 != 0 && (f3[1:0] == 2'b01 || (f3[1] && z != 0));
    e_ill = csr_en && f3 != 0 && (f3 == 3'b100 || !hit || (a[11:10] == 2'b11 && wr));
    e_rd  = csr_en ? v : 32'd0;
    src   = f3[2] ? 32'(z) : wd;
    case (f3[1:0])
      2'b01:   e_wv = src;
      2'b10:   e_wv = v | src;
      2'b11:   e_wv = v & ~src;
      default: e_wv = v;
    endcase
    pend = mip & m_mie;
    code = -1;
    foreach (PRIO[k]) if (code < 0 && pend[PRIO[k]]) code = PRIO[k];
    take    = m_msie && code >= 0 && int_ok && !ex_valid;
    e_code  = code;
    e_trap  = ex_valid || take;
    e_tpc   = (m_mtvec & ~32'd3) + ((take && m_mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'd0);
    e_eret  = csr_en && f3 == 0 && a == 12'h302;
    e_epc   = m_mepc & ~32'd3;
    e_do_wr = wr && !e_ill && !e_trap;
    e_a     = a;
  endtask

  task automatic update();
    if (!rst) begin
      m_msie = 0; m_mpie = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
      m_mtval = 0; m_mscratch = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    if (e_do_wr && e_a == 12'hB00)      m_cyc[31:0]  = e_wv;
    else if (e_do_wr && e_a == 12'hB80) m_cyc[63:32] = e_wv;
    else if (!m_inh[0])                 m_cyc = m_cyc + 1;
    if (e_do_wr && e_a == 12'hB02)      m_ins[31:0]  = e_wv;
    else if (e_do_wr && e_a == 12'hB82) m_ins[63:32] = e_wv;
    else if (retire && !m_inh[2])       m_ins = m_ins + 1;
    if (e_trap) begin
      m_mepc = pc & ~32'd3;
      m_mpie = m_msie;
      m_msie = 0;
      if (ex_valid) begin
        m_mcause = 32'(ex_cause);
        case (ex_cause)
          4'd0, 4'd4, 4'd6: m_mtval = badaddr;
          4'd2:             m_mtval = inst;
          4'd3:             m_mtval = pc;
          default:          m_mtval = 0;
        endcase
      end else begin
        m_mcause = 32'h8000_0000 | 32'(e_code);
        m_mtval  = 0;
      end
    end else if (e_eret) begin
      m_msie = m_mpie;
      m_mpie = 1;
    end else if (e_do_wr) begin
      case (e_a)
        12'h300: begin m_msie = e_wv[3]; m_mpie = e_wv[7]; end
        12'h304: m_mie = e_wv & 32'h000F_0888;
        12'h305: m_mtvec = e_wv & 32'hFFFF_FFFD;
        12'h320: m_inh = e_wv & 32'h5;
        12'h340: m_mscratch = e_wv;
        12'h341: m_mepc = e_wv & ~32'd3;
        12'h342: m_mcause = e_wv;
        12'h343: m_mtval = e_wv;
        default: ;
      endcase
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    eval();
    if (chk) begin
      check("model_rd", o_rd, e_rd);
      check("model_illegal", 32'(o_illegal), 32'(e_ill));
      check("model_trap", 32'(o_trap), 32'(e_trap));
      check("model_trap_pc", o_trap_pc, e_tpc);
      check("model_eret", 32'(o_eret), 32'(e_eret));
      check("model_epc", o_epc, e_epc);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle_in();
    csr_en = 0; inst = 0; wd = 0; ex_valid = 0; ex_cause = 0; retire = 0; int_ok = 0;
    pc = 32'h100; badaddr = 0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] rs, input logic [31:0] w);
    idle_in();
    csr_en = 1; inst = ci(a, f3, rs); wd = w;
    at_neg(); at_pos();
  endtask

  task automatic rd_check(input string nm, input logic [11:0] a, input logic [31:0] exp);
    idle_in();
    csr_en = 1; inst = ci(a, 3'b010, 5'd0);
    at_neg();
    check(nm, o_rd, exp);
    at_pos();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ill;
  } vec_t;
  vec_t tbl[10];

  int addrs[18] = '{'h300, 'h301, 'h304, 'h305, 'h320, 'h340, 'h341, 'h342, 'h343,
                    'h344, 'hB00, 'hB02, 'hB80, 'hB82, 'hF11, 'hF14, 'h302, 'h7C0};
  int causes[6] = '{0, 2, 3, 4, 6, 11};

  initial begin
    tbl[0] = '{ci(12'h301, 3'b010, 5'd0), 32'd0, 32'h4000_0100, 1'b0};
    tbl[1] = '{ci(12'hF14, 3'b010, 5'd0), 32'd0, HART, 1'b0};
    tbl[2] = '{ci(12'hF14, 3'b001, 5'd2), 32'd9, HART, 1'b1};
    tbl[3] = '{ci(12'h300, 3'b010, 5'd0), 32'd0, 32'h1800, 1'b0};
    tbl[4] = '{ci(12'h340, 3'b001, 5'd2), 32'h1234_5678, 32'd0, 1'b0};
    tbl[5] = '{ci(12'h340, 3'b010, 5'd0), 32'd0, 32'h1234_5678, 1'b0};
    tbl[6] = '{ci(12'h7C0, 3'b010, 5'd0), 32'd0, 32'd0, 1'b1};
    tbl[7] = '{ci(12'h340, 3'b100, 5'd3), 32'd0, 32'h1234_5678, 1'b1};
    tbl[8] = '{ci(12'hF14, 3'b110, 5'd0), 32'd0, HART, 1'b0};
    tbl[9] = '{ci(12'hF14, 3'b111, 5'd1), 32'd0, HART, 1'b1};

    rst = 0; msi = 0; mti = 0; mei = 0; lirq = 0;
    idle_in();
    at_neg(); at_pos();
    at_neg(); at_pos();
    rst = 1; chk = 1;

    // Reset state with all inputs idle
    at_neg();
    check("rst_trap", 32'(o_trap), 0);
    check("rst_trap_pc", o_trap_pc, 0);
    check("rst_epc", o_epc, 0);
    check("rst_illegal", 32'(o_illegal), 0);
    at_pos();

    // Counters: one cycle already elapsed, nine more idle, then read
    repeat (9) begin at_neg(); at_pos(); end
    rd_check("mcycle_10", 12'hB00, 32'd10);
    for (int i = 0; i < 3; i++) begin
      idle_in(); retire = 1; at_neg(); at_pos();
      idle_in(); at_neg(); at_pos();
    end
    rd_check("minstret_3", 12'hB02, 32'd3);

    foreach (tbl[i]) begin
      idle_in();
      csr_en = 1; inst = tbl[i].inst; wd = tbl[i].wd;
      at_neg();
      check($sformatf("tbl%0d_rd", i), o_rd, tbl[i].rd);
      check($sformatf("tbl%0d_ill", i), 32'(o_illegal), 32'(tbl[i].ill));
      at_pos();
    end

    // Vectored external interrupt
    csr(12'h305, 3'b001, 5'd1, 32'h8000_0101);
    csr(12'h304, 3'b001, 5'd1, 32'h0000_0800);
    csr(12'h300, 3'b110, 5'd8, 32'd0);
    idle_in(); mei = 1; int_ok = 1;
    at_neg();
    check("mei_trap", 32'(o_trap), 1);
    check("mei_trap_pc", o_trap_pc, 32'h8000_012C);
    at_pos();
    mei = 0;
    rd_check("mei_mcause", 12'h342, 32'h8000_000B);
    rd_check("mei_mstatus", 12'h300, 32'h0000_1880);

    // Timer beats local[2]; local[2] alone afterwards
    csr(12'h304, 3'b001, 5'd1, 32'h0004_0880);
    csr(12'h300, 3'b110, 5'd8, 32'd0);
    idle_in(); mti = 1; lirq = 4'b0100; int_ok = 1;
    at_neg(); at_pos();
    rd_check("mti_mcause", 12'h342, 32'h8000_0007);
    csr(12'h300, 3'b110, 5'd8, 32'd0);
    idle_in(); mti = 0; int_ok = 1;
    at_neg(); at_pos();
    lirq = 0;
    rd_check("lirq2_mcause", 12'h342, 32'h8000_0012);

    // Exception with a concurrent CSR write that must be dropped
    idle_in();
    csr_en = 1; inst = ci(12'h340, 3'b001, 5'd2); wd = 32'hDEAD;
    ex_valid = 1; ex_cause = 4; badaddr = 32'h1003;
    at_neg();
    check("ex_trap", 32'(o_trap), 1);
    at_pos();
    rd_check("ex_mtval", 12'h343, 32'h1003);
    rd_check("ex_mcause", 12'h342, 32'h4);
    rd_check("ex_mscratch", 12'h340, 32'h1234_5678);

    // 32-bit carry into mcycleh, and write-beats-increment
    csr(12'hB80, 3'b001, 5'd1, 32'd0);
    csr(12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF);
    idle_in(); at_neg(); at_pos();
    rd_check("mcycle_wrap_lo", 12'hB00, 32'd0);
    rd_check("mcycle_wrap_hi", 12'hB80, 32'd1);
    csr(12'hB00, 3'b001, 5'd1, 32'h55);
    rd_check("mcycle_wr_noinc", 12'hB00, 32'h55);

    // MRET
    csr(12'h341, 3'b001, 5'd1, 32'h1237);
    csr(12'h300, 3'b001, 5'd1, 32'h80);
    idle_in(); csr_en = 1; inst = 32'h3020_0073;
    at_neg();
    check("mret_eret", 32'(o_eret), 1);
    check("mret_epc", o_epc, 32'h1234);
    at_pos();
    rd_check("mret_mstatus", 12'h300, 32'h0000_1888);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] f3;
      logic [4:0] z;
      rst      = ($urandom_range(0, 199) != 0);
      csr_en   = $urandom_range(0, 1);
      f3       = 3'($urandom_range(0, 7));
      z        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      inst     = ci(12'(addrs[$urandom_range(0, 17)]), f3, z);
      if (f3 == 0 && $urandom_range(0, 1) == 1) inst = 32'h3020_0073;
      wd       = $urandom;
      ex_valid = ($urandom_range(0, 9) == 0);
      ex_cause = 4'(causes[$urandom_range(0, 5)]);
      pc       = $urandom & ~32'd3;
      badaddr  = $urandom;
      retire   = $urandom_range(0, 1);
      int_ok   = $urandom_range(0, 1);
      msi      = ($urandom_range(0, 4) == 0);
      mti      = ($urandom_range(0, 4) == 0);
      mei      = ($urandom_range(0, 4) == 0);
      lirq     = 4'($urandom) & 4'($urandom);
      at_neg(); at_pos();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the RV32 core. Successor to the single-timer CSR block.
- Adds N local interrupt lines, software and external interrupts, a fixed priority encoder, and vectored or direct trap entry.
- Adds mcycle/minstret counters with configurable width, mcountinhibit, and illegal-CSR detection.
- Sits in the execute stage. It gives the fetch stage trap and return targets.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- HART_ID, 0, value read from mhartid.
- N_LIRQ, 4, number of local interrupts (1..16). They map to mcause codes 16..16+N_LIRQ-1 and to mie/mip bits 16+i.
- CNT_W, 64, width of mcycle and minstret (33..64). mcycleh and minstreth return bits CNT_W-1:32, zero-extended.
- VEC_EN, 1, when 1 the mtvec.MODE=01 setting is honoured. When 0, MODE is hardwired to 00.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-low reset
- i_csr_en  in  1  a CSR or SYSTEM instruction is valid this cycle
- i_inst  in  32  instruction word; funct3=[14:12], addr=[31:20], zimm=[19:15]
- i_wd  in  XLEN  rs1 value
- o_rd  out  XLEN  CSR read data (combinational)
- o_illegal  out  1  illegal CSR access (combinational)
- i_pc  in  XLEN  PC of the current instruction
- i_badaddr  in  XLEN  faulting address
- i_ex_valid  in  1  synchronous exception this cycle
- i_ex_cause  in  4  exception code (0,2,3,4,6,11)
- i_retire  in  1  one instruction retires this cycle
- i_int_ok  in  1  pipeline is at an interruptible boundary
- i_irq_msi, i_irq_mti, i_irq_mei  in  1 each  level-sensitive software, timer and external interrupts
- i_irq_local  in  N_LIRQ  level-sensitive local interrupts
- o_trap  out  1  take a trap now
- o_trap_pc  out  XLEN  trap target
- o_eret  out  1  MRET executing
- o_epc  out  XLEN  return target, {mepc[31:2],2'b00}

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - mstatus.MIE=0, MPIE=0, mie=0, mtvec=0, mepc=0, mcause=0, mtval=0, mscratch=0, mcountinhibit=0, mcycle=0, minstret=0.
  - All outputs are combinational from this state. With no inputs active, every output is 0.
  - Reset in the middle of any activity overrides all pending writes and traps.
- Read-only registers: mstatus.MPP reads 2'b11; misa = 0x40000100; mhartid = HART_ID.
- mip is combinational: bit 3=msi, bit 7=mti, bit 11=mei, bit 16+i=local[i].
- CSR operations (i_csr_en=1, funct3≠000):
  - Source is zimm if funct3[2]=1, otherwise i_wd.
  - 01 write; 10 set (old|src); 11 clear (old&~src).
  - For set and clear, no write occurs when the rs1 field (zimm) is 0. The read still happens.
  - The write commits at the next edge. o_rd returns the old value in the same cycle.
- o_illegal=1 when any of these holds. The core must then raise i_ex_valid with cause 2.
  - addr is unimplemented.
  - addr[11:10]=2'b11 and a write would occur.
  - funct3=100.
- Writable-bit masks:
  - mtvec: base[31:2]; mode bit 0 only when VEC_EN.
  - mepc: [31:2].
  - mie: bits 3, 7, 11, 16..16+N_LIRQ-1.
  - mcountinhibit: bits 0 (CY) and 2 (IR).
- Counters:
  - mcycle increments every cycle unless CY=1.
  - minstret increments when i_retire=1 unless IR=1.
  - Both wrap modulo 2^CNT_W.
  - A CSR write to the low or high half in the same cycle takes precedence: the written half is loaded, the other half is held, and there is no increment that cycle.
- Interrupts:
  - pend = mip & mie.
  - Priority: MEI(11) > MSI(3) > MTI(7) > local[0] (16) > ... > local[N_LIRQ-1].
  - An interrupt is taken when MIE=1, pend≠0, i_int_ok=1 and i_ex_valid=0.
- Trap (o_trap=1, combinational):
  - Asserted on i_ex_valid or on a taken interrupt.
  - Exceptions win over interrupts.
  - When o_trap=1, any CSR write in the same cycle is suppressed.
  - At the next edge: mepc=i_pc; MPIE=MIE; MIE=0.
  - Exception: mcause={0,cause}. mtval = i_badaddr for causes 0, 4 and 6; i_inst for cause 2; i_pc for cause 3; 0 otherwise.
  - Interrupt: mcause={1,code}, mtval=0.
- o_trap_pc:
  - Equals {mtvec[31:2],00}.
  - Plus 4*code when mode=01 and the trap is an interrupt.
- MRET (funct3=000, addr=0x302):
  - o_eret=1.
  - Next edge: MIE=MPIE, MPIE=1.
  - If o_trap=1 in the same cycle, the trap wins and MRET has no state effect. o_eret is still driven, and the core gives priority to o_trap.

Test Plan:
- Reset, then read misa → 0x40000100. mcycle after 10 idle cycles → 10. minstret with i_retire pulsed 3 times → 3.
- Set mtvec=0x80000101 (VEC_EN=1), mie=0x800, MIE=1. Raise mei with i_int_ok=1 → o_trap=1, o_trap_pc=0x8000012C. Next cycle: mcause=0x8000000B, MIE=0, MPIE=1.
- Assert mti and local[2] together with both enabled → mcause=0x80000007. Then drop mti → next trap has mcause=0x80000012.
- i_ex_valid with cause 4, badaddr=0x1003, and a concurrent CSRRW to mscratch → mtval=0x1003, mcause=4, mscratch unchanged.
- mcycle=0xFFFFFFFF with CNT_W=64 → next cycle mcycleh=1 and mcycle=0. A write to mcycle in the same cycle loads the written value and there is no increment.
- CSRRW to mhartid (0xF14) → o_illegal=1. CSRRS x0 to mhartid → o_illegal=0 and o_rd=HART_ID. MRET with MPIE=1 → MIE=1 and o_epc=mepc&~3.
